// File: rtl/parity_pkg.sv
// Shared definitions for the parity-protected serial receiver.
// Holds the receiver FSM state encoding, the start/stop bit levels and a
// helper that returns the frame length in clock cycles for a given width.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Cycles per frame: start + data bits + parity + stop.
  function automatic int unsigned frame_len(input int unsigned data_w);
    return data_w + 32'd3;
  endfunction

endpackage

// File: rtl/par_shift_in.sv
// Serial-in / parallel-out shift register.
// New bits enter at the LSB, so an MSB-first stream ends up in natural order.
// Ports:
//   clk_i      - clock
//   rst_ni     - asynchronous active-low reset
//   shift_en_i - shift sdin_i in on this edge
//   sdin_i     - serial input bit
//   data_o     - parallel contents of the register
module par_shift_in #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              shift_en_i,
  input  logic              sdin_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (shift_en_i) begin
      data_q <= {data_q[DATA_W-2:0], sdin_i};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/parity_rx.sv
// Serial receiver for the parity-protected serial link.
// Frame: start bit 1, DATA_W data bits MSB-first, even-parity bit, stop bit 0.
// The completed word and its error flags are presented with a one-cycle
// Valid strobe and held until the next frame completes.
// Build option: define PARITY_RX_STOP_CHECK_EN to flag a stop bit of 1 on
// frame_error; otherwise the stop slot is consumed but ignored.
// Ports:
//   Clk         - clock, all state changes on the rising edge
//   Rst_n       - asynchronous active-low reset
//   SDin        - serial line, idles low
//   PDout       - last received data word
//   Valid       - one-cycle strobe, PDout and flags updated
//   par_error   - parity mismatch on last frame
//   frame_error - stop bit not 0 on last frame
//   Busy        - frame in progress
module parity_rx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              SDin,
  output logic [DATA_W-1:0] PDout,
  output logic              Valid,
  output logic              par_error,
  output logic              frame_error,
  output logic              Busy
);

  localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              par_bit_q;
  logic [DATA_W-1:0] pdout_q;
  logic              valid_q;
  logic              par_err_q;
  logic              frame_err_q;
  logic              busy_q;
  logic [DATA_W-1:0] shift_data;
  logic              shift_en_c;

  // Data bits are shifted in on every DATA-state edge.
  assign shift_en_c = (state_q == DATA);

  par_shift_in #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .shift_en_i (shift_en_c),
    .sdin_i     (SDin),
    .data_o     (shift_data)
  );

  // Receiver FSM with registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      par_bit_q   <= 1'b0;
      pdout_q     <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (SDin == START_BIT) begin
            state_q <= DATA;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DATA: begin
          // Counter stops at the last index instead of wrapping.
          if (cnt_q == CNT_LAST) begin
            state_q <= PARITY;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          par_bit_q <= SDin;
          state_q   <= STOP;
        end
        STOP: begin
          // Errored frames are delivered too; the flags travel with Valid.
          pdout_q   <= shift_data;
          par_err_q <= (^shift_data) ^ par_bit_q;
`ifdef PARITY_RX_STOP_CHECK_EN
          frame_err_q <= (SDin != STOP_BIT);
`else
          frame_err_q <= 1'b0;
`endif
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          // A 1 in the stop slot is never treated as a new start bit.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PDout       = pdout_q;
  assign Valid       = valid_q;
  assign par_error   = par_err_q;
  assign frame_error = frame_err_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_parity_rx.sv
// Self-checking bench for parity_rx (DATA_W = 8).
module tb_parity_rx;
  import parity_pkg::*;

  localparam int unsigned DW = 8;

`ifdef PARITY_RX_STOP_CHECK_EN
  localparam bit STOP_CHK = 1'b1;
`else
  localparam bit STOP_CHK = 1'b0;
`endif

  logic          Clk;
  logic          Rst_n;
  logic          SDin;
  logic [DW-1:0] PDout;
  logic          Valid;
  logic          par_error;
  logic          frame_error;
  logic          Busy;

  parity_rx #(.DATA_W(DW)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .SDin        (SDin),
    .PDout       (PDout),
    .Valid       (Valid),
    .par_error   (par_error),
    .frame_error (frame_error),
    .Busy        (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int valid_cnt = 0;
  always @(negedge Clk) if (Valid === 1'b1) valid_cnt <= valid_cnt + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_pd;
    logic       exp_pe;
    logic       stop_bad;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one full frame; returns #1 after the stop-bit edge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            output int start_cyc, output int stop_cyc);
    SDin = 1'b1;
    @(posedge Clk); #1;
    start_cyc = cyc;
    chk("busy_after_start", 32'(Busy), 32'd1);
    for (int i = DW - 1; i >= 0; i--) begin
      SDin = d[i];
      @(posedge Clk); #1;
    end
    SDin = p;
    @(posedge Clk); #1;
    SDin = s;
    @(posedge Clk); #1;
    stop_cyc = cyc;
  endtask

  task automatic check_done(input logic [7:0] pd, input logic pe, input logic fe);
    chk("valid", 32'(Valid), 32'd1);
    chk("pdout", 32'(PDout), 32'(pd));
    chk("par_error", 32'(par_error), 32'(pe));
    chk("frame_error", 32'(frame_error), 32'(fe));
    chk("busy_with_valid", 32'(Busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_cyc, e_cyc, e1, e2, exp_valid;
    logic exp_fe;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
    exp_valid = 0;

    Rst_n = 1'b0;
    SDin  = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_pdout", 32'(PDout), 32'd0);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_par_error", 32'(par_error), 32'd0);
    chk("rst_frame_error", 32'(frame_error), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Table of single frames separated by idle gaps.
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, s_cyc, e_cyc);
      exp_valid++;
      exp_fe = STOP_CHK ? vecs[v].stop_bad : 1'b0;
      chk("latency", 32'(e_cyc - s_cyc), 32'(DW + 2));
      check_done(vecs[v].exp_pd, vecs[v].exp_pe, exp_fe);
      SDin = 1'b0;
      @(posedge Clk); #1;
      chk("valid_one_cycle", 32'(Valid), 32'd0);
      chk("busy_idle", 32'(Busy), 32'd0);
      chk("pdout_hold", 32'(PDout), 32'(vecs[v].exp_pd));
      chk("par_error_hold", 32'(par_error), 32'(vecs[v].exp_pe));
      repeat (2) @(posedge Clk);
      #1;
    end

    // Back-to-back frames: second start bit in the cycle right after stop.
    send_frame(8'h3C, 1'b0, 1'b0, s_cyc, e1);
    check_done(8'h3C, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, s_cyc, e2);
    check_done(8'h81, 1'b0, 1'b0);
    exp_valid += 2;
    chk("b2b_spacing", 32'(e2 - e1), 32'(frame_len(DW)));
    SDin = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("b2b_valid_count", 32'(valid_cnt), 32'(exp_valid));

    // Reset in the middle of a 0xFF frame.
    SDin = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("midframe_busy", 32'(Busy), 32'd1);
    Rst_n = 1'b0;
    SDin  = 1'b0;
    #1;
    chk("async_rst_busy", 32'(Busy), 32'd0);
    chk("async_rst_pdout", 32'(PDout), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    chk("post_rst_pdout", 32'(PDout), 32'd0);
    chk("post_rst_valid", 32'(Valid), 32'd0);
    chk("post_rst_par_error", 32'(par_error), 32'd0);
    chk("post_rst_frame_error", 32'(frame_error), 32'd0);
    chk("post_rst_busy", 32'(Busy), 32'd0);
    chk("post_rst_valid_count", 32'(valid_cnt), 32'(exp_valid));

    // Line idle low: nothing must start.
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      chk("idle_busy", 32'(Busy), 32'd0);
      chk("idle_valid", 32'(Valid), 32'd0);
    end
    chk("final_valid_count", 32'(valid_cnt), 32'(exp_valid));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
